// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - CPU load/store sequencer onto a fixed-latency memory port
module mem_access_ctrl #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        byte_op,
    input  logic        sign_ext,
    input  logic [17:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        misalign_err,
    output logic [17:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_byte
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state;
    state_t      next_state;
    logic        lat_we;
    logic        lat_sext;
    logic [3:0]  cnt;
    logic        accept;
    logic        misaligned;
    logic        last_cycle;
    logic [7:0]  byte_sel;
    logic [31:0] load_value;

    assign accept     = (state == IDLE) && req;
    assign misaligned = !byte_op && (addr[1:0] != 2'b00);
    assign last_cycle = (state == ACCESS) && (cnt == 4'd0);

    // Odd byte addresses take the low lane, even ones the next lane up.
    assign byte_sel   = mem_address[0] ? mem_read_data[7:0] : mem_read_data[15:8];
    assign load_value = !mem_byte ? mem_read_data
                      : {(lat_sext ? {24{byte_sel[7]}} : 24'h0), byte_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = misaligned ? ERR : ACCESS;
            ACCESS:  if (cnt == 4'd0) next_state = DONE;
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        done         = (state == DONE) || (state == ERR);
        misalign_err = (state == ERR);
        mem_read     = (state == ACCESS) && !lat_we;
        mem_write    = last_cycle && lat_we;
    end

    // Memory-side address/data only move on an accepted aligned access, so they hold through ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we         <= 1'b0;
            lat_sext       <= 1'b0;
            cnt            <= 4'd0;
            mem_address    <= 18'd0;
            mem_write_data <= 32'd0;
            mem_byte       <= 1'b0;
            rdata          <= 32'd0;
        end else begin
            if (accept) begin
                lat_we   <= we;
                lat_sext <= sign_ext;
                cnt      <= CNT_INIT;
                if (!misaligned) begin
                    mem_address    <= addr;
                    mem_write_data <= wdata;
                    mem_byte       <= byte_op;
                end
            end else if ((state == ACCESS) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (last_cycle && !lat_we) begin
                rdata <= load_value;
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, meaning the number of clock cycles a memory access is held on the memory-side port (legal 1..15).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  1  CPU access request, sampled only in IDLE.
REQ-005 SHALL have port we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port byte_op  input  1  1 = byte access, 0 = word access.
REQ-007 SHALL have port sign_ext  input  1  for byte loads: 1 = sign-extend, 0 = zero-extend.
REQ-008 SHALL have port addr  input  18  CPU byte address.
REQ-009 SHALL have port wdata  input  32  CPU store data.
REQ-010 SHALL have port rdata  output  32  load result, registered, held until the next load completes.
REQ-011 SHALL have port busy  output  1  high from the accept cycle until the done cycle, inclusive.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port misalign_err  output  1  asserted together with done when the access was rejected.
REQ-014 SHALL have ports mem_address (output, 18), mem_write_data (output, 32), mem_read_data (input, 32), mem_read (output, 1), mem_write (output, 1), mem_byte (output, 1), forming the memory-side port.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCESS, DONE and ERR.
REQ-016 In IDLE with req=1, SHALL latch we, byte_op, sign_ext, addr and wdata, and assert busy from the next cycle.
- Word access with addr[1:0] != 0: next state ERR.
- Otherwise: next state ACCESS.
REQ-017 SHALL ignore req in any state other than IDLE; the latched fields SHALL NOT change until return to IDLE.
REQ-018 ERR SHALL last one cycle with done=1 and misalign_err=1, generate no mem_read or mem_write, leave rdata unchanged, then go to IDLE.
REQ-019 During ACCESS, the memory-side outputs SHALL be driven from the latched fields:
- mem_address = latched addr, mem_byte = latched byte_op, mem_write_data = latched wdata.
- They SHALL be held stable for the whole ACCESS period.
REQ-020 ACCESS SHALL last exactly MEM_LATENCY cycles, counted by a 4-bit down-counter loaded with MEM_LATENCY-1 on accept.
REQ-021 For loads, mem_read SHALL be 1 for every ACCESS cycle; for stores, mem_read SHALL be 0.
REQ-022 For stores, mem_write SHALL be 1 only in the last ACCESS cycle (exactly one cycle per store), and 0 otherwise.
REQ-023 On the last ACCESS cycle of a load, SHALL register rdata from mem_read_data:
- Word load: rdata = mem_read_data.
- Byte load: byte = mem_read_data[7:0] if addr[0]=1, else mem_read_data[15:8]; rdata = {24 copies of byte[7] if sign_ext else 24'h0, byte}.
REQ-024 DONE SHALL last one cycle with done=1 and misalign_err=0, then go to IDLE.
- Stores SHALL leave rdata unchanged.
REQ-025 done SHALL rise exactly MEM_LATENCY+1 rising edges after the accept edge; the ERR path SHALL give done 1 edge after accept.
REQ-026 busy SHALL be 1 in ACCESS, DONE and ERR and 0 in IDLE; a new req may be accepted in the cycle after done.
REQ-027 Outside ACCESS, mem_read and mem_write SHALL be 0; mem_address, mem_write_data and mem_byte SHALL hold their last values.

Reset
REQ-028 While rst_n=0, and asynchronously on its assertion, SHALL set the following and clear the latched fields and counter to 0:
- state = IDLE.
- rdata = 0, busy = 0, done = 0, misalign_err = 0.
- mem_read = 0, mem_write = 0, mem_address = 0, mem_write_data = 0, mem_byte = 0.
REQ-029 Reset asserted mid-ACCESS SHALL abort the access with no done pulse; a store aborted before its last ACCESS cycle SHALL produce no mem_write pulse.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept a req.

Verification
REQ-031 Word store then load, MEM_LATENCY=1:
- req, we=1, addr=0x00010, wdata=0xDEADBEEF -> one mem_write pulse with mem_address=0x00010, done 2 edges later.
- Load of the same address with mem_read_data=0xDEADBEEF -> rdata=0xDEADBEEF.
REQ-032 Byte load sign extension: addr=0x00005, mem_read_data=0x000000F3:
- sign_ext=1 -> rdata=0xFFFFFFF3.
- sign_ext=0 -> rdata=0x000000F3.
- addr=0x00004, mem_read_data=0x00008000, sign_ext=1 -> rdata=0xFFFFFF80.
REQ-033 Misaligned word load at addr=0x00006 -> done=1 and misalign_err=1 one edge after accept, mem_read never asserted, rdata unchanged.
REQ-034 MEM_LATENCY=4 store:
- mem_read=0 and mem_address stable for 4 cycles, mem_write high only in cycle 4, done at edge 5.
- A second req during busy is ignored.
REQ-035 Reset in the 2nd ACCESS cycle of a MEM_LATENCY=4 store -> no mem_write pulse and no done; all outputs 0 immediately; a req in the first cycle after release is accepted.
